// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder: XADC-style DRP register slave with an emulated conversion sequencer.
module xadc_drp_responder #(
    parameter int DRP_LATENCY = 4,
    parameter int CONV_CYCLES = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DEN,
    input  logic        DWE,
    input  logic [6:0]  DADDR,
    input  logic [15:0] DI,
    input  logic        CONVST,
    input  logic [15:0] sample_in,
    output logic [15:0] DO,
    output logic        DRDY,
    output logic        BUSY,
    output logic        EOC,
    output logic        EOS,
    output logic [4:0]  CHANNEL,
    output logic        drp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} drp_t;
    typedef enum logic {CIDLE, CONV} conv_t;

    drp_t        drp_q, drp_d;
    conv_t       conv_q, conv_d;
    logic [3:0]  lat_q, lat_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [6:0]  addr_q;
    logic        we_q;
    logic [15:0] di_q, rd;
    logic        err_q, err_d;
    logic [15:0] cfg0_q, cfg0_d, cfg1_q, cfg1_d, cfg2_q, cfg2_d;
    logic [15:0] temp_q, temp_d, vpvn_q, vpvn_d;
    logic [4:0]  chan_q, chan_d;
    logic        seqm_q, seqm_d, nxt3_q, nxt3_d;
    logic        cv_q, edge_q, wr, start;

    always_comb begin
        rd = 16'h0000;
        case (addr_q)
            7'h00: rd = temp_q;
            7'h03: rd = vpvn_q;
            7'h40: rd = cfg0_q;
            7'h41: rd = cfg1_q;
            7'h42: rd = cfg2_q;
            default: rd = 16'h0000;
        endcase
    end

    always_comb begin
        drp_d   = drp_q;
        lat_d   = lat_q;
        if (drp_q == IDLE && DEN) begin
            drp_d = WAIT;
            lat_d = 4'(DRP_LATENCY - 2);
        end else if (drp_q == WAIT) begin
            drp_d = (lat_q == 4'd0) ? ACK : WAIT;
            lat_d = lat_q - 4'd1;
        end else if (drp_q == ACK) begin
            drp_d = IDLE;
        end
        DRDY    = drp_q == ACK;
        DO      = DRDY ? rd : 16'h0000;
        wr      = DRDY && we_q;
        err_d   = err_q | (DEN && drp_q != IDLE);
        cfg0_d  = (wr && addr_q == 7'h40) ? di_q : cfg0_q;
        cfg1_d  = (wr && addr_q == 7'h41) ? di_q : cfg1_q;
        cfg2_d  = (wr && addr_q == 7'h42) ? di_q : cfg2_q;
        // Mode and channel are sampled only at start, so config writes land on the next conversion.
        start   = conv_q == CIDLE && (cfg0_q[9] ? edge_q : 1'b1);
        BUSY    = conv_q == CONV;
        EOC     = BUSY && cnt_q == 8'd0;
        EOS     = EOC && (!seqm_q || chan_q == 5'd3);
        conv_d  = start ? CONV : (EOC ? CIDLE : conv_q);
        cnt_d   = start ? 8'(CONV_CYCLES - 1) : (BUSY ? cnt_q - 8'd1 : cnt_q);
        chan_d  = start ? (cfg1_q[0] ? (nxt3_q ? 5'd3 : 5'd0) : cfg0_q[4:0]) : chan_q;
        seqm_d  = start ? cfg1_q[0] : seqm_q;
        nxt3_d  = !cfg1_q[0] ? 1'b0 : (start ? ~nxt3_q : nxt3_q);
        temp_d  = (EOC && chan_q == 5'd0) ? sample_in : temp_q;
        vpvn_d  = (EOC && chan_q == 5'd3) ? sample_in : vpvn_q;
        CHANNEL = chan_q;
        drp_err = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drp_q  <= IDLE;
            conv_q <= CIDLE;
            lat_q  <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            di_q   <= '0;
            err_q  <= 1'b0;
            cfg0_q <= '0;
            cfg1_q <= '0;
            cfg2_q <= '0;
            temp_q <= '0;
            vpvn_q <= '0;
            chan_q <= '0;
            seqm_q <= 1'b0;
            nxt3_q <= 1'b0;
            cv_q   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            drp_q  <= drp_d;
            conv_q <= conv_d;
            lat_q  <= lat_d;
            cnt_q  <= cnt_d;
            if (drp_q == IDLE && DEN) begin
                addr_q <= DADDR;
                we_q   <= DWE;
                di_q   <= DI;
            end
            err_q  <= err_d;
            cfg0_q <= cfg0_d;
            cfg1_q <= cfg1_d;
            cfg2_q <= cfg2_d;
            temp_q <= temp_d;
            vpvn_q <= vpvn_d;
            chan_q <= chan_d;
            seqm_q <= seqm_d;
            nxt3_q <= nxt3_d;
            cv_q   <= CONVST;
            edge_q <= CONVST & ~cv_q;
        end
    end
endmodule

// File: tb/tb_xadc_drp_responder.sv
// tb_xadc_drp_responder: directed checks of the DRP slave and conversion sequencer.
module tb_xadc_drp_responder;
    logic        clk = 0, rst = 1, DEN = 0, DWE = 0, CONVST = 0;
    logic [6:0]  DADDR = 0;
    logic [15:0] DI = 0, sample_in = 0;
    logic [15:0] DO;
    logic        DRDY, BUSY, EOC, EOS, drp_err;
    logic [4:0]  CHANNEL;
    int vec = 0, err = 0;

    xadc_drp_responder dut (
        .clk(clk), .rst(rst), .DEN(DEN), .DWE(DWE), .DADDR(DADDR), .DI(DI),
        .CONVST(CONVST), .sample_in(sample_in), .DO(DO), .DRDY(DRDY), .BUSY(BUSY),
        .EOC(EOC), .EOS(EOS), .CHANNEL(CHANNEL), .drp_err(drp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drp(input logic [6:0] a, input logic we, input logic [15:0] d, output logic [15:0] q);
        int lat;
        DEN = 1; DWE = we; DADDR = a; DI = d;
        tick();
        DEN = 0; DWE = 0;
        lat = 1;
        while (!DRDY && lat < 20) begin
            tick();
            lat++;
        end
        q = DO;
        chk("drp_latency", lat, 4);
        tick();
    endtask

    initial begin
        logic [15:0] q;
        logic [4:0] chs[3];
        logic eoss[3];
        logic [15:0] vals[4];
        int n, ne, neos, nd;
        logic upd;
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;

        sample_in = 16'hABCD;
        repeat (3) tick();
        chk("rst_drdy", DRDY, 0);
        chk("rst_do", DO, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_eoc", EOC, 0);
        chk("rst_eos", EOS, 0);
        chk("rst_chan", CHANNEL, 0);
        chk("rst_err", drp_err, 0);
        rst = 0;
        chk("c0_busy", BUSY, 0);
        tick();
        chk("c1_busy", BUSY, 1);
        repeat (24) tick();
        chk("c25_eoc", EOC, 0);
        tick();
        chk("c26_eoc", EOC, 1);
        chk("c26_eos", EOS, 1);
        chk("c26_chan", CHANNEL, 0);
        tick();
        chk("c27_busy", BUSY, 0);
        chk("c27_eoc", EOC, 0);
        tick();
        chk("c28_busy", BUSY, 1);

        drp(7'h00, 0, 0, q);       chk("rd_temp", q, 16'hABCD);
        chk("do_idle", DO, 0);
        drp(7'h40, 1, 16'h0203, q);
        drp(7'h40, 0, 0, q);       chk("rd_cfg0", q, 16'h0203);
        drp(7'h7F, 0, 0, q);       chk("rd_unmapped", q, 16'h0000);
        drp(7'h00, 1, 16'h1234, q);
        drp(7'h00, 0, 0, q);       chk("rd_temp_ro", q, 16'hABCD);

        repeat (60) tick();
        chk("evt_idle", BUSY, 0);
        sample_in = 16'h5555;
        CONVST = 1;
        tick();
        CONVST = 0;
        ne = 0; neos = 0;
        for (int i = 0; i < 80; i++) begin
            if (i == 5 || i == 10) begin
                chk("evt_busy_at_pulse", BUSY, 1);
                CONVST = 1;
            end else CONVST = 0;
            tick();
            ne += int'(EOC);
            neos += int'(EOS);
        end
        chk("evt_eoc_count", ne, 1);
        chk("evt_eos_count", neos, 1);
        chk("evt_chan", CHANNEL, 3);
        chk("evt_done", BUSY, 0);
        drp(7'h03, 0, 0, q);       chk("rd_vpvn_evt", q, 16'h5555);

        drp(7'h41, 1, 16'h0001, q);
        sample_in = vals[0];
        drp(7'h40, 1, 16'h0000, q);
        n = 0; upd = 0;
        for (int i = 0; i < 200 && n < 3; i++) begin
            tick();
            if (upd) begin
                sample_in = vals[n];
                upd = 0;
            end
            if (EOC) begin
                chs[n] = CHANNEL;
                eoss[n] = EOS;
                n++;
                upd = 1;
            end
        end
        chk("seq_eoc_count", n, 3);
        if (n == 3) begin
            chk("seq_ch0", chs[0], 0);
            chk("seq_ch1", chs[1], 3);
            chk("seq_ch2", chs[2], 0);
            chk("seq_eos0", eoss[0], 0);
            chk("seq_eos1", eoss[1], 1);
            chk("seq_eos2", eoss[2], 0);
        end
        drp(7'h03, 0, 0, q);       chk("rd_vpvn_seq", q, 16'h2222);
        drp(7'h00, 0, 0, q);       chk("rd_temp_seq", q, 16'h3333);

        DEN = 1; DWE = 0; DADDR = 7'h40;
        tick();
        DEN = 0;
        tick();
        DEN = 1;
        tick();
        DEN = 0;
        nd = int'(DRDY);
        for (int i = 0; i < 15; i++) begin
            tick();
            nd += int'(DRDY);
        end
        chk("dup_drdy_count", nd, 1);
        chk("dup_err", drp_err, 1);

        rst = 1;
        tick();
        chk("rst2_err", drp_err, 0);
        rst = 0;
        chk("rst2_busy", BUSY, 0);
        DEN = 1; DWE = 1; DADDR = 7'h41; DI = 16'h00FF;
        tick();
        DEN = 0; DWE = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            nd += int'(DRDY);
            tick();
        end
        chk("abort_drdy_count", nd, 0);
        drp(7'h41, 0, 0, q);       chk("rd_cfg1_abort", q, 16'h0000);
        drp(7'h42, 1, 16'hBEEF, q);
        drp(7'h42, 0, 0, q);       chk("rd_cfg2", q, 16'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/xadc_drp_responder.md
XADC_DRP_RESPONDER -- requirements
Module: xadc_drp_responder

Interface
REQ-001 Parameter DRP_LATENCY, default 4: cycles from the accepted DEN edge to DRDY (legal range 2..15).
REQ-002 Parameter CONV_CYCLES, default 26: cycles per conversion, counted from conversion start to EOC (legal range 4..255).
REQ-003 clk  in  1  sole clock; all logic on the rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 DEN  in  1  DRP enable; a one-cycle pulse requests a transaction.
REQ-006 DWE  in  1  DRP write enable; qualifies DEN.
REQ-007 DADDR  in  7  DRP register address.
REQ-008 DI  in  16  DRP write data.
REQ-009 CONVST  in  1  conversion-start event input; used in event mode only.
REQ-010 sample_in  in  16  emulated analog value, sampled at end of conversion.
REQ-011 DO  out  16  DRP read data; valid only while DRDY=1.
REQ-012 DRDY  out  1  one-cycle transaction-complete pulse.
REQ-013 BUSY  out  1  high while a conversion is in progress.
REQ-014 EOC  out  1  one-cycle end-of-conversion pulse.
REQ-015 EOS  out  1  one-cycle end-of-sequence pulse.
REQ-016 CHANNEL  out  5  channel of the current or most recent conversion.
REQ-017 drp_err  out  1  sticky flag: DEN received while a transaction is outstanding.

Function
REQ-018 Register map:
- 0x00 TEMP result, read-only.
- 0x03 VPVN result, read-only.
- 0x40 CFG0, read/write.
- 0x41 CFG1, read/write.
- 0x42 CFG2, read/write.
- Any other address reads 16'h0000; writes to it are ignored.
- Writes to 0x00 and 0x03 are ignored but still complete with DRDY.
REQ-019 DRP FSM has three states: IDLE, WAIT, ACK.
- IDLE: DEN=1 latches DADDR, DWE and DI, then moves to WAIT.
- WAIT: a counter holds the FSM for DRP_LATENCY-1 cycles, then moves to ACK.
- ACK: lasts one cycle, drives DRDY=1, then returns to IDLE.
REQ-020 Write commit: a write updates the target register in the ACK cycle.
REQ-021 Read data: DO is the addressed register's value as held at the start of the ACK cycle; an EOC update in that same cycle is not visible.
REQ-022 DO is 16'h0000 whenever DRDY=0.
REQ-023 DEN=1 while in WAIT or ACK is ignored: no new transaction starts, and drp_err is set until reset.
REQ-024 DEN=1 in the same cycle as ACK is also ignored.
REQ-025 Conversion mode:
- CFG0[9]=0 is continuous mode: a new conversion starts on the cycle after the previous EOC.
- CFG0[9]=1 is event mode: a conversion starts on the cycle after a 0->1 transition of CONVST (registered), and only when not BUSY.
- CONVST edges while BUSY are ignored.
REQ-026 Channel selection:
- CFG1[0]=0 (single): CHANNEL = CFG0[4:0], sampled at conversion start.
- CFG1[0]=1 (sequence): channels alternate 0, 3, 0, 3, ... starting at 0.
REQ-027 Conversion FSM has two states: CIDLE and CONV.
- BUSY=1 exactly while in CONV.
- On the final CONV cycle, EOC pulses and the result register of CHANNEL loads sample_in.
- Channels other than 0 and 3 produce EOC but store nothing.
REQ-028 EOS pulses with EOC:
- Sequence mode: on each channel-3 conversion.
- Single mode: on every conversion.
REQ-029 A write to CFG0 or CFG1 while BUSY does not affect the running conversion; it applies from the next conversion start.
- If the write sets sequence mode, the sequence restarts at channel 0.
REQ-030 Result registers hold their value until overwritten by a later EOC.

Reset
REQ-031 Reset values:
- Outputs: DO=0, DRDY=0, BUSY=0, EOC=0, EOS=0, CHANNEL=0, drp_err=0.
- Registers: CFG0, CFG1, CFG2, TEMP and VPVN all 16'h0000.
- Both FSMs go to their idle state.
REQ-032 Reset asserted mid-transaction aborts it: no DRDY is produced and no write is committed.
REQ-033 Reset asserted mid-conversion aborts it: no EOC is produced.
REQ-034 In the first cycle after rst deasserts, the default continuous mode starts a conversion on channel 0.

Verification
REQ-035 Write 0x40=16'h0203, DRP_LATENCY=4 -> DRDY 4 cycles after DEN; read 0x40 returns 16'h0203; read 0x7F returns 16'h0000.
REQ-036 Defaults, sample_in=16'hABCD -> EOC at cycle 26 after reset release; read 0x00 returns 16'hABCD; BUSY low only for the EOC-following start cycle.
REQ-037 CFG1=1, sample_in changed per conversion -> CHANNEL sequence 0, 3, 0; EOS only with channel 3's EOC; 0x03 holds the second sample.
REQ-038 Second DEN issued 2 cycles after the first -> exactly one DRDY; drp_err=1 until rst.
REQ-039 CFG0[9]=1, CONVST pulsed twice while BUSY -> exactly one EOC per accepted edge; the edges during BUSY are ignored.
REQ-040 rst asserted during WAIT of a write to 0x41 -> no DRDY; 0x41 reads 16'h0000 after reset.
